pet_stat_bank: RTL and testbench
================================

Name: pet_stat_bank

Overview:
- Parametrised successor of the Tamagotchi stat register bank: holds NUM_STATS saturating pet stats plus a day counter and a life-state FSM.
- Events, periodic decay and the test-mode adjust path are applied in one arbitrated update per tick, so no event is ever silently dropped.
- Sits between the debounced button/sensor front end and the display/sprite logic; runs on the system clock with a one-cycle tick strobe, not a derived clock.

Parameters:
- NUM_STATS, 4, number of stats (index 0 SALUD, 1 ANIMO, 2 COMIDA, 3 ENERGIA for the default build)
- STAT_W, 3, bits per stat
- STAT_MAX, 5, saturation ceiling; also reset value
- LOW_THRESH, 2, a stat below this value clears its health flag
- DAY_W, 6, day counter width
- DAY_LIMIT, 32, day count that forces DEAD
- DECAY_TICKS, 50, ticks between decay steps (each stat -1)
- DAY_TICKS, 150, ticks per day increment
- DELTA_W, 3, signed width of each per-stat event delta

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- tick  in  1  one-cycle strobe; all counting and stat updates happen only on tick cycles
- evt_valid  in  1  event strobe, sampled on tick cycles only
- evt_delta  in  NUM_STATS*DELTA_W  packed signed deltas; stat i uses bits [i*DELTA_W +: DELTA_W]
- test_en  in  1  enables the select/adjust path
- sel_next, sel_prev  in  1  cursor pulses
- adj_inc, adj_dec  in  1  adjust pulses; act on the selected item
- stat_flat  out  NUM_STATS*STAT_W  current stats
- health_flags  out  NUM_STATS  bit i = 1 when stat i >= LOW_THRESH
- days  out  DAY_W  day counter
- dead  out  1  FSM is in DEAD
- sel_idx  out  clog2(NUM_STATS+1)  cursor position; NUM_STATS selects days
- sel_value  out  DAY_W  value at cursor, zero-extended

Behaviour:
- Reset (async assert, sync release) sets: all stats = STAT_MAX; health_flags all 1; days = 0; dead = 0; sel_idx = 0; internal counters = 0; FSM = ALIVE.
- All state changes occur on clk edges where tick = 1. Non-tick cycles hold every register. Outputs are registered, so results are visible one cycle after the tick.
- Decay counter counts 0..DECAY_TICKS-1. On wrap, decay_d = -1 for every stat on that tick.
- Day counter counts 0..DAY_TICKS-1. On wrap, days increments.
- Per stat per tick, the next value is the saturation to [0, STAT_MAX] of: stat + decay_d + (evt_valid ? evt_delta_i : 0) + adj_d_i.
  - adj_d_i = +1 for adj_inc, -1 for adj_dec (0 when both are set), applied only when test_en = 1 and sel_idx = i.
  - The sum is computed at STAT_W+DELTA_W+1 bits signed; saturation is applied exactly once.
- Cursor moves only when test_en = 1 and state is ALIVE.
  - sel_next wraps NUM_STATS -> 0; sel_prev wraps 0 -> NUM_STATS.
  - sel_next and sel_prev together: no move.
  - With sel_idx = NUM_STATS, adj_inc/adj_dec change days by ±1, saturating at 0 and DAY_LIMIT.
- health_flags are registered from the post-update stats.
- FSM:
  - ALIVE -> DEAD when the post-update days >= DAY_LIMIT, or when all stats are 0.
  - In DEAD: stats, days and health_flags are forced to 0; events, decay and adjust are ignored; counters freeze.
  - DEAD exits only through rst.
- Reset mid-update aborts the update; no partial values survive.

Decomposition:
- Shared package pet_pkg: stat index constants (STAT_SALUD=0 ... STAT_ENERGIA=3), the FSM state enum {ALIVE, DEAD}, and a sat_add function.
- One natural sub-module, pet_stat_cell: one stat register with saturating add, the adjust-select compare and the flag output, instantiated NUM_STATS times by a generate loop.
- The day counter, tick counters, cursor and FSM stay in the top level.

Test Plan:
1. Reset, then 50 ticks with no events: at tick 50 every stat goes 5->4; health_flags = 4'b1111; days = 0.
2. A tick with evt_valid and deltas {+3,-1,-2,+1} on stats at 4, combined with a decay wrap on the same tick -> stats {5,2,1,4}: saturated, both contributions counted.
3. test_en = 1, sel_next x2, adj_dec x5 on COMIDA starting at 5 -> COMIDA = 0; health_flags[2] = 0 once COMIDA reaches 1; no underflow.
4. sel_prev from 0 -> sel_idx = 4 (days); adj_inc ×32 -> days = 32 -> dead = 1 the next cycle; later events leave all outputs at 0.
5. Drive all stats to 0 through events -> dead = 1; assert rst mid-run -> all stats 5 and dead = 0 immediately (asynchronously).
6. Hold tick low for 1000 cycles while events and buttons toggle -> no output changes.

Source files
------------

// File: rtl/pet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pet_pkg
//  Description : Shared stat indices, life-state encoding and the clamp
//                helper used by the pet stat bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package pet_pkg;

    localparam int STAT_SALUD   = 0;
    localparam int STAT_ANIMO   = 1;
    localparam int STAT_COMIDA  = 2;
    localparam int STAT_ENERGIA = 3;

    typedef enum logic [0:0] {
        ALIVE = 1'b0,
        DEAD  = 1'b1
    } life_state_e;

    // Adds a signed delta to a base and clamps the result into [0, hi].
    function automatic int sat_add(input int base, input int delta, input int hi);
        int sum;
        sum = base + delta;
        if (sum < 0)
            return 0;
        else if (sum > hi)
            return hi;
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pet_stat_cell.sv
`default_nettype none
// ============================================================================
//  Module      : pet_stat_cell
//  Description : One saturating pet stat. Folds decay, event delta and the
//                cursor-selected adjust into a single clamped update, and
//                registers the health flag from the updated value.
//  Revision    : 1.0 - initial release
// ============================================================================
module pet_stat_cell
    import pet_pkg::*;
#(
    parameter int IDX        = 0,
    parameter int STAT_W     = 3,
    parameter int STAT_MAX   = 5,
    parameter int LOW_THRESH = 2,
    parameter int DELTA_W    = 3,
    parameter int SEL_W      = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      kill_i,
    input  logic                      decay_i,
    input  logic                      evt_valid_i,
    input  logic signed [DELTA_W-1:0] evt_delta_i,
    input  logic                      test_en_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic                      adj_inc_i,
    input  logic                      adj_dec_i,
    output logic [STAT_W-1:0]         stat_o,
    output logic [STAT_W-1:0]         stat_d_o,
    output logic                      flag_o
);

    localparam int SUM_W = STAT_W + DELTA_W + 1;
    localparam logic signed [SUM_W-1:0] ONE = 1;

    logic signed [SUM_W-1:0] delta_d;
    logic [STAT_W-1:0]       stat_q;
    logic [STAT_W-1:0]       stat_d;
    logic                    flag_q;

    // Sum every contribution first so the clamp is applied exactly once.
    always_comb begin
        delta_d = '0;
        if (decay_i)
            delta_d = delta_d - ONE;
        if (evt_valid_i)
            delta_d = delta_d + $signed({{(SUM_W-DELTA_W){evt_delta_i[DELTA_W-1]}}, evt_delta_i});
        if (test_en_i && (sel_i == SEL_W'(IDX)) && (adj_inc_i ^ adj_dec_i))
            delta_d = adj_inc_i ? (delta_d + ONE) : (delta_d - ONE);
        stat_d = STAT_W'(sat_add(int'(stat_q), int'(delta_d), STAT_MAX));
    end

    // Stat and flag register; a kill from the life FSM zeroes both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_q <= STAT_W'(STAT_MAX);
            flag_q <= (STAT_MAX >= LOW_THRESH);
        end else if (en_i) begin
            if (kill_i) begin
                stat_q <= '0;
                flag_q <= 1'b0;
            end else begin
                stat_q <= stat_d;
                flag_q <= (int'(stat_d) >= LOW_THRESH);
            end
        end
    end

    assign stat_o   = stat_q;
    assign stat_d_o = stat_d;
    assign flag_o   = flag_q;

endmodule
`default_nettype wire

// File: rtl/pet_stat_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pet_stat_bank
//  Description : Bank of saturating pet stats with decay and day counters,
//                test-mode cursor/adjust path and an ALIVE/DEAD life FSM.
//                Every state change happens on tick cycles only.
//  Revision    : 1.0 - initial release
// ============================================================================
module pet_stat_bank
    import pet_pkg::*;
#(
    parameter int NUM_STATS   = 4,
    parameter int STAT_W      = 3,
    parameter int STAT_MAX    = 5,
    parameter int LOW_THRESH  = 2,
    parameter int DAY_W       = 6,
    parameter int DAY_LIMIT   = 32,
    parameter int DECAY_TICKS = 50,
    parameter int DAY_TICKS   = 150,
    parameter int DELTA_W     = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 tick_i,
    input  logic                                 evt_valid_i,
    input  logic [NUM_STATS*DELTA_W-1:0]         evt_delta_i,
    input  logic                                 test_en_i,
    input  logic                                 sel_next_i,
    input  logic                                 sel_prev_i,
    input  logic                                 adj_inc_i,
    input  logic                                 adj_dec_i,
    output logic [NUM_STATS*STAT_W-1:0]          stat_flat_o,
    output logic [NUM_STATS-1:0]                 health_flags_o,
    output logic [DAY_W-1:0]                     days_o,
    output logic                                 dead_o,
    output logic [$clog2(NUM_STATS+1)-1:0]       sel_idx_o,
    output logic [DAY_W-1:0]                     sel_value_o
);

    localparam int SEL_W  = $clog2(NUM_STATS + 1);
    localparam int DEC_W  = $clog2(DECAY_TICKS);
    localparam int DAYC_W = $clog2(DAY_TICKS);

    life_state_e       state_q;
    logic [DEC_W-1:0]  dec_cnt_q;
    logic [DAYC_W-1:0] day_cnt_q;
    logic [DAY_W-1:0]  days_q, days_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic              update;
    logic              decay_wrap;
    logic              day_wrap;
    logic              all_zero;
    logic              kill;
    int                days_delta;

    logic [STAT_W-1:0] stat_arr   [NUM_STATS];
    logic [STAT_W-1:0] stat_d_arr [NUM_STATS];
    logic [NUM_STATS-1:0] flags;

    assign update     = tick_i && (state_q == ALIVE);
    assign decay_wrap = (dec_cnt_q == DEC_W'(DECAY_TICKS - 1));
    assign day_wrap   = (day_cnt_q == DAYC_W'(DAY_TICKS - 1));

    generate
        for (genvar i = 0; i < NUM_STATS; i++) begin : g_cell
            pet_stat_cell #(
                .IDX        (i),
                .STAT_W     (STAT_W),
                .STAT_MAX   (STAT_MAX),
                .LOW_THRESH (LOW_THRESH),
                .DELTA_W    (DELTA_W),
                .SEL_W      (SEL_W)
            ) u_cell (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .en_i        (update),
                .kill_i      (kill),
                .decay_i     (decay_wrap),
                .evt_valid_i (evt_valid_i),
                .evt_delta_i (evt_delta_i[i*DELTA_W +: DELTA_W]),
                .test_en_i   (test_en_i),
                .sel_i       (sel_q),
                .adj_inc_i   (adj_inc_i),
                .adj_dec_i   (adj_dec_i),
                .stat_o      (stat_arr[i]),
                .stat_d_o    (stat_d_arr[i]),
                .flag_o      (flags[i])
            );
            assign stat_flat_o[i*STAT_W +: STAT_W] = stat_arr[i];
        end
    endgenerate

    // Day value after wrap increment and cursor adjust, clamped to [0, DAY_LIMIT].
    always_comb begin
        days_delta = 0;
        if (day_wrap)
            days_delta = days_delta + 1;
        if (test_en_i && (sel_q == SEL_W'(NUM_STATS)) && (adj_inc_i ^ adj_dec_i))
            days_delta = adj_inc_i ? (days_delta + 1) : (days_delta - 1);
        days_d = DAY_W'(sat_add(int'(days_q), days_delta, DAY_LIMIT));
    end

    // Death check uses post-update values: day limit reached or every stat empty.
    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_STATS; i++)
            if (stat_d_arr[i] != '0)
                all_zero = 1'b0;
        kill = (int'(days_d) >= DAY_LIMIT) || all_zero;
    end

    // Cursor step with wrap; simultaneous next/prev cancel out.
    always_comb begin
        sel_d = sel_q;
        if (test_en_i && sel_next_i && !sel_prev_i)
            sel_d = (sel_q == SEL_W'(NUM_STATS)) ? '0 : (sel_q + 1'b1);
        else if (test_en_i && sel_prev_i && !sel_next_i)
            sel_d = (sel_q == '0) ? SEL_W'(NUM_STATS) : (sel_q - 1'b1);
    end

    // Tick counters, day register, cursor and life FSM; all frozen once DEAD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ALIVE;
            dec_cnt_q <= '0;
            day_cnt_q <= '0;
            days_q    <= '0;
            sel_q     <= '0;
        end else if (update) begin
            dec_cnt_q <= decay_wrap ? '0 : (dec_cnt_q + 1'b1);
            day_cnt_q <= day_wrap   ? '0 : (day_cnt_q + 1'b1);
            sel_q     <= sel_d;
            if (kill) begin
                days_q  <= '0;
                state_q <= DEAD;
            end else begin
                days_q  <= days_d;
                state_q <= ALIVE;
            end
        end
    end

    // Value under the cursor; the slot past the last stat shows the day count.
    always_comb begin
        sel_value_o = days_q;
        for (int i = 0; i < NUM_STATS; i++)
            if (sel_q == SEL_W'(i))
                sel_value_o = DAY_W'(stat_arr[i]);
    end

    assign health_flags_o = flags;
    assign days_o         = days_q;
    assign dead_o         = (state_q == DEAD);
    assign sel_idx_o      = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_pet_stat_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pet_stat_bank
//  Description : Directed self-checking bench for pet_stat_bank with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pet_stat_bank;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tick_i = 1'b0;
    logic        evt_valid_i = 1'b0;
    logic [11:0] evt_delta_i = '0;
    logic        test_en_i = 1'b0;
    logic        sel_next_i = 1'b0;
    logic        sel_prev_i = 1'b0;
    logic        adj_inc_i = 1'b0;
    logic        adj_dec_i = 1'b0;
    logic [11:0] stat_flat_o;
    logic [3:0]  health_flags_o;
    logic [5:0]  days_o;
    logic        dead_o;
    logic [2:0]  sel_idx_o;
    logic [5:0]  sel_value_o;

    int n_total = 0;
    int n_bad   = 0;

    pet_stat_bank u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tick_i         (tick_i),
        .evt_valid_i    (evt_valid_i),
        .evt_delta_i    (evt_delta_i),
        .test_en_i      (test_en_i),
        .sel_next_i     (sel_next_i),
        .sel_prev_i     (sel_prev_i),
        .adj_inc_i      (adj_inc_i),
        .adj_dec_i      (adj_dec_i),
        .stat_flat_o    (stat_flat_o),
        .health_flags_o (health_flags_o),
        .days_o         (days_o),
        .dead_o         (dead_o),
        .sel_idx_o      (sel_idx_o),
        .sel_value_o    (sel_value_o)
    );

    always #5 clk_i = ~clk_i;

    // Packs four 3-bit fields, index 0 in the low bits.
    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        logic [2:0] fa, fb, fc, fd;
        fa = 3'(a); fb = 3'(b); fc = 3'(c); fd = 3'(d);
        return {fd, fc, fb, fa};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One tick cycle with the given strobes; returns at the following negedge.
    task automatic do_tick(input logic ev, input logic [11:0] dl, input logic ten,
                           input logic nx, input logic pv, input logic inc, input logic dec);
        @(negedge clk_i);
        tick_i = 1'b1; evt_valid_i = ev; evt_delta_i = dl; test_en_i = ten;
        sel_next_i = nx; sel_prev_i = pv; adj_inc_i = inc; adj_dec_i = dec;
        @(negedge clk_i);
        tick_i = 1'b0; evt_valid_i = 1'b0; evt_delta_i = '0; test_en_i = 1'b0;
        sel_next_i = 1'b0; sel_prev_i = 1'b0; adj_inc_i = 1'b0; adj_dec_i = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++)
            do_tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] hold_stats;

        // Reset state
        do_reset();
        chk("rst_stats", 32'(stat_flat_o), 32'(pk(5, 5, 5, 5)));
        chk("rst_flags", 32'(health_flags_o), 32'hF);
        chk("rst_days",  32'(days_o), 0);
        chk("rst_dead",  32'(dead_o), 0);
        chk("rst_sel",   32'(sel_idx_o), 0);

        // 1: first decay lands on tick 50
        idle_ticks(49);
        chk("t1_pre_decay", 32'(stat_flat_o), 32'(pk(5, 5, 5, 5)));
        idle_ticks(1);
        chk("t1_decay", 32'(stat_flat_o), 32'(pk(4, 4, 4, 4)));
        chk("t1_flags", 32'(health_flags_o), 32'hF);
        chk("t1_days",  32'(days_o), 0);

        // 2: event + decay on tick 100, {+3,-1,-2,+1}
        idle_ticks(49);
        do_tick(1'b1, pk(3, -1, -2, 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_stats", 32'(stat_flat_o), 32'(pk(5, 2, 1, 4)));
        chk("t2_flags", 32'(health_flags_o), 32'b1011);

        // 3: cursor to COMIDA, decrement down to 0 with no underflow
        do_reset();
        do_tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_sel", 32'(sel_idx_o), 2);
        chk("t3_selval", 32'(sel_value_o), 5);
        do_tick(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t3_both_nomove", 32'(sel_idx_o), 2);
        chk("t3_both_noadj", 32'(stat_flat_o), 32'(pk(5, 5, 5, 5)));
        do_tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_noten_noadj", 32'(stat_flat_o), 32'(pk(5, 5, 5, 5)));
        for (int k = 0; k < 3; k++)
            do_tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_at2_stats", 32'(stat_flat_o), 32'(pk(5, 5, 2, 5)));
        chk("t3_at2_flags", 32'(health_flags_o), 32'hF);
        do_tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_at1_flags", 32'(health_flags_o), 32'b1011);
        do_tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_floor", 32'(stat_flat_o), 32'(pk(5, 5, 0, 5)));
        chk("t3_alive", 32'(dead_o), 0);
        do_tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_sel4", 32'(sel_idx_o), 4);
        do_tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_wrap0", 32'(sel_idx_o), 0);

        // 4: prev wraps to days slot, 32 increments reach the limit
        do_reset();
        do_tick(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_sel", 32'(sel_idx_o), 4);
        for (int k = 0; k < 10; k++)
            do_tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_selval10", 32'(sel_value_o), 10);
        do_tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_daydec", 32'(days_o), 9);
        for (int k = 0; k < 22; k++)
            do_tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_days31", 32'(days_o), 31);
        chk("t4_alive31", 32'(dead_o), 0);
        do_tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_dead", 32'(dead_o), 1);
        chk("t4_days0", 32'(days_o), 0);
        chk("t4_stats0", 32'(stat_flat_o), 0);
        chk("t4_flags0", 32'(health_flags_o), 0);
        do_tick(1'b1, pk(3, 3, 3, 3), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_ign_stats", 32'(stat_flat_o), 0);
        chk("t4_ign_days", 32'(days_o), 0);
        chk("t4_ign_sel", 32'(sel_idx_o), 4);
        chk("t4_still_dead", 32'(dead_o), 1);

        // 5: events empty every stat, then asynchronous reset mid-cycle
        do_reset();
        do_tick(1'b1, pk(-4, -4, -4, -4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_step1", 32'(stat_flat_o), 32'(pk(1, 1, 1, 1)));
        chk("t5_flags", 32'(health_flags_o), 0);
        chk("t5_alive", 32'(dead_o), 0);
        do_tick(1'b1, pk(-4, -4, -4, -4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_dead", 32'(dead_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t5_async_stats", 32'(stat_flat_o), 32'(pk(5, 5, 5, 5)));
        chk("t5_async_dead", 32'(dead_o), 0);
        chk("t5_async_flags", 32'(health_flags_o), 32'hF);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 6: no tick for 1000 cycles, inputs toggling; counters stay frozen too
        do_tick(1'b1, pk(-1, -1, -1, -1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold_stats = pk(4, 4, 4, 4);
        chk("t6_start", 32'(stat_flat_o), 32'(hold_stats));
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk_i);
            evt_valid_i = 1'($urandom);
            evt_delta_i = 12'($urandom);
            test_en_i   = 1'($urandom);
            sel_next_i  = 1'($urandom);
            sel_prev_i  = 1'($urandom);
            adj_inc_i   = 1'($urandom);
            adj_dec_i   = 1'($urandom);
            if (k % 250 == 249) begin
                chk("t6_hold_stats", 32'(stat_flat_o), 32'(hold_stats));
                chk("t6_hold_sel", 32'(sel_idx_o), 0);
            end
        end
        @(negedge clk_i);
        evt_valid_i = 1'b0; evt_delta_i = '0; test_en_i = 1'b0;
        sel_next_i = 1'b0; sel_prev_i = 1'b0; adj_inc_i = 1'b0; adj_dec_i = 1'b0;
        chk("t6_hold_days", 32'(days_o), 0);
        idle_ticks(48);
        chk("t6_cnt_frozen", 32'(stat_flat_o), 32'(pk(4, 4, 4, 4)));
        idle_ticks(1);
        chk("t6_decay50", 32'(stat_flat_o), 32'(pk(3, 3, 3, 3)));

        // 7: day wrap at tick 150 with three decays
        do_reset();
        idle_ticks(149);
        chk("t7_days_pre", 32'(days_o), 0);
        chk("t7_stats_pre", 32'(stat_flat_o), 32'(pk(3, 3, 3, 3)));
        idle_ticks(1);
        chk("t7_days", 32'(days_o), 1);
        chk("t7_stats", 32'(stat_flat_o), 32'(pk(2, 2, 2, 2)));
        chk("t7_flags", 32'(health_flags_o), 32'hF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
